// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential single-cycle-latency reads into a small in-order queue
// and presents the head to the core; Redirect flushes and restarts fetch at a new word address.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemRdData,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrOut,
  output logic [31:0] PCOut,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        AddrErr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] Cap = (CntW + 1)'(DEPTH);

  logic [31:0]     fetchPcQ, fetchPcD;
  logic [31:0]     reqPcQ;
  logic            outstandingQ;
  logic [CntW-1:0] countQ, countD;
  logic [PtrW-1:0] headQ, headD, tailQ, tailD;
  logic [31:0]     instrMem [DEPTH];
  logic [31:0]     pcMem    [DEPTH];

  logic            pop, push, canIssue;
  logic [CntW:0]   occupancy;

  always_comb begin
    pop       = (countQ != '0) && InstrReady && !Rst;
    // Slots committed once this cycle settles: queued + in flight - leaving.
    occupancy = {1'b0, countQ} + (CntW + 1)'(outstandingQ) - (CntW + 1)'(pop);
    canIssue  = occupancy < Cap;
    ImemReq   = !Rst && !Redirect && canIssue;
    ImemAddr  = fetchPcQ;
    push      = outstandingQ && !Redirect && !Rst;
    AddrErr   = !Rst && Redirect && (RedirectPC[1:0] != 2'b00);
  end

  always_comb begin
    fetchPcD = fetchPcQ;
    countD   = countQ;
    headD    = headQ;
    tailD    = tailQ;
    if (Redirect) begin
      fetchPcD = {RedirectPC[31:2], 2'b00};
      countD   = '0;
      headD    = '0;
      tailD    = '0;
    end else begin
      if (ImemReq) fetchPcD = fetchPcQ + 32'd4;
      if (push)    tailD    = tailQ + 1'b1;
      if (pop)     headD    = headQ + 1'b1;
      case ({push, pop})
        2'b10:   countD = countQ + 1'b1;
        2'b01:   countD = countQ - 1'b1;
        default: countD = countQ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetchPcQ     <= RESET_PC;
      reqPcQ       <= RESET_PC;
      outstandingQ <= 1'b0;
      countQ       <= '0;
      headQ        <= '0;
      tailQ        <= '0;
    end else begin
      fetchPcQ     <= fetchPcD;
      outstandingQ <= ImemReq;
      countQ       <= countD;
      headQ        <= headD;
      tailQ        <= tailD;
      if (ImemReq) reqPcQ <= fetchPcQ;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    if (push) begin
      instrMem[tailQ] <= ImemRdData;
      pcMem[tailQ]    <= reqPcQ;
    end
  end

  always_comb begin
    InstrValid = (countQ != '0) && !Rst;
    InstrOut   = InstrValid ? instrMem[headQ] : 32'h0;
    PCOut      = InstrValid ? pcMem[headQ] : 32'h0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected PCs, a negedge monitor checks every
// delivered instruction; directed checks cover reset, latency, full, redirect and wraparound.
module tb_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdData;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrOut;
  logic [31:0] PCOut;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        AddrErr;

  int          nChecks = 0;
  int          nErrors = 0;
  logic [31:0] sb[$];
  logic [31:0] monExp;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemRdData(ImemRdData),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .InstrOut  (InstrOut),
    .PCOut     (PCOut),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .AddrErr   (AddrErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory returns addr+1 one cycle after the request.
  always @(posedge Clk) ImemRdData <= ImemReq ? ImemAddr + 32'd1 : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic expectPcs(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) sb.push_back(first + 32'(4 * i));
  endtask

  always @(negedge Clk) begin
    if (InstrValid && InstrReady) begin
      if (sb.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("FAIL unexpected_delivery: got PCOut %h, expected no delivery", PCOut);
      end else begin
        monExp = sb.pop_front();
        check("deliver_pc", PCOut, monExp);
        check("deliver_instr", InstrOut, monExp + 32'd1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b1; InstrReady = 1'b1; Redirect = 1'b0; RedirectPC = 32'h0;

    // Reset state, and Redirect ignored during reset.
    nxt(); #1;
    check("rst_req", 32'(ImemReq), 32'd0);
    check("rst_valid", 32'(InstrValid), 32'd0);
    check("rst_adderr", 32'(AddrErr), 32'd0);
    check("rst_instr", InstrOut, 32'h0);
    check("rst_pc", PCOut, 32'h0);
    nxt(); Redirect = 1'b1; RedirectPC = 32'h43; #1;
    check("rst_redir_adderr", 32'(AddrErr), 32'd0);
    check("rst_redir_req", 32'(ImemReq), 32'd0);

    // Streaming with InstrReady=1: latency 2, one per cycle.
    nxt(); Redirect = 1'b0; Rst = 1'b0; expectPcs(32'h0, 6); #1;
    check("a_c0_req", 32'(ImemReq), 32'd1);
    check("a_c0_addr", ImemAddr, 32'h0);
    check("a_c0_valid", 32'(InstrValid), 32'd0);
    nxt(); #1;
    check("a_c1_addr", ImemAddr, 32'h4);
    check("a_c1_valid", 32'(InstrValid), 32'd0);
    nxt(); #1;
    check("a_c2_addr", ImemAddr, 32'h8);
    check("a_c2_valid", 32'(InstrValid), 32'd1);
    repeat (5) nxt();
    nxt(); Rst = 1'b1; InstrReady = 1'b0; #1;
    check("a_rst_valid", 32'(InstrValid), 32'd0);
    check("a_drain", 32'(sb.size()), 32'd0);

    // Fill with InstrReady=0, then resume without gap or duplicate.
    nxt(); Rst = 1'b0; expectPcs(32'h0, 5); #1;
    check("b_c0_addr", ImemAddr, 32'h0);
    nxt(); #1;
    check("b_c1_req", 32'(ImemReq), 32'd1);
    check("b_c1_addr", ImemAddr, 32'h4);
    nxt(); #1;
    check("b_c2_req", 32'(ImemReq), 32'd0);
    check("b_c2_pc", PCOut, 32'h0);
    nxt(); nxt(); #1;
    check("b_full_req", 32'(ImemReq), 32'd0);
    check("b_hold_pc", PCOut, 32'h0);
    check("b_hold_instr", InstrOut, 32'h1);
    nxt(); InstrReady = 1'b1; #1;
    check("b_resume_req", 32'(ImemReq), 32'd1);
    check("b_resume_addr", ImemAddr, 32'h8);
    repeat (4) nxt();
    nxt(); Rst = 1'b1; InstrReady = 1'b0; #1;
    check("b_drain", 32'(sb.size()), 32'd0);

    // Redirect with queue at capacity and a request outstanding.
    nxt(); Rst = 1'b0;
    nxt();
    nxt(); Redirect = 1'b1; RedirectPC = 32'h40; #1;
    check("c_redir_req", 32'(ImemReq), 32'd0);
    check("c_redir_adderr", 32'(AddrErr), 32'd0);
    nxt(); Redirect = 1'b0; InstrReady = 1'b1; expectPcs(32'h40, 2); #1;
    check("c_r1_valid", 32'(InstrValid), 32'd0);
    check("c_r1_req", 32'(ImemReq), 32'd1);
    check("c_r1_addr", ImemAddr, 32'h40);
    nxt(); #1;
    check("c_r2_valid", 32'(InstrValid), 32'd0);
    check("c_r2_addr", ImemAddr, 32'h44);
    nxt(); #1;
    check("c_r3_valid", 32'(InstrValid), 32'd1);
    check("c_r3_pc", PCOut, 32'h40);

    // Misaligned redirect with a pop in the same cycle.
    nxt(); Redirect = 1'b1; RedirectPC = 32'h43; expectPcs(32'h40, 3); #1;
    check("c_mis_adderr", 32'(AddrErr), 32'd1);
    check("c_mis_req", 32'(ImemReq), 32'd0);
    nxt(); Redirect = 1'b0; #1;
    check("c_mis_adderr_off", 32'(AddrErr), 32'd0);
    check("c_mis_valid", 32'(InstrValid), 32'd0);
    check("c_mis_addr", ImemAddr, 32'h40);
    nxt(); #1;
    check("c_mis_valid2", 32'(InstrValid), 32'd0);
    repeat (3) nxt();

    // Back-to-back redirects: the last target wins, then wrap past 2^32.
    nxt(); InstrReady = 1'b0; Redirect = 1'b1; RedirectPC = 32'h100; #1;
    check("d_r1_req", 32'(ImemReq), 32'd0);
    nxt(); RedirectPC = 32'hFFFF_FFF8; #1;
    check("d_r2_req", 32'(ImemReq), 32'd0);
    check("d_r2_valid", 32'(InstrValid), 32'd0);
    nxt(); Redirect = 1'b0; InstrReady = 1'b1; expectPcs(32'hFFFF_FFF8, 3); #1;
    check("d_addr0", ImemAddr, 32'hFFFF_FFF8);
    nxt(); #1;
    check("d_addr1", ImemAddr, 32'hFFFF_FFFC);
    nxt(); #1;
    check("d_addr_wrap", ImemAddr, 32'h0);
    check("d_pc0", PCOut, 32'hFFFF_FFF8);
    nxt(); nxt();

    // Mid-operation reset with an entry queued and a response in flight.
    nxt(); Rst = 1'b1; #1;
    check("e_rst_valid", 32'(InstrValid), 32'd0);
    check("e_rst_req", 32'(ImemReq), 32'd0);
    check("e_drain", 32'(sb.size()), 32'd0);
    nxt(); Rst = 1'b0; expectPcs(32'h0, 2); #1;
    check("e_c0_valid", 32'(InstrValid), 32'd0);
    check("e_c0_req", 32'(ImemReq), 32'd1);
    check("e_c0_addr", ImemAddr, 32'h0);
    nxt(); #1;
    check("e_c1_valid", 32'(InstrValid), 32'd0);
    nxt(); #1;
    check("e_c2_pc", PCOut, 32'h0);
    nxt();
    nxt(); InstrReady = 1'b0;
    repeat (3) nxt();
    check("final_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
